// File: rtl/accumulating_adder.sv
// Board adding machine: debounced keys add/subtract SW into a registered accumulator,
// shown on active-low hex 7-segment digits with sticky overflow on the LEDs.

module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_key_n,
    output logic o_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        WAIT_PRESS,
        FIRE,
        WAIT_RELEASE
    } state_t;

    logic [1:0]       r_sync;
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_pulse;
    logic             w_level;
    logic             w_done;

    assign w_level = r_sync[1];
    // The qualifying cycle itself counts, so DEBOUNCE_CYCLES=0 or 1 acts on the first one.
    assign w_done  = (32'(r_cnt) + 32'd1) >= 32'(DEBOUNCE_CYCLES);
    assign o_pulse = r_pulse;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= 2'b11;
            r_state <= WAIT_PRESS;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_key_n};
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_pulse <= (r_state == FIRE);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            WAIT_PRESS: begin
                if (!w_level) begin
                    if (w_done) begin
                        w_state_next = FIRE;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_cnt_next = '0;
                end
            end
            FIRE: begin
                w_state_next = WAIT_RELEASE;
                w_cnt_next   = '0;
            end
            WAIT_RELEASE: begin
                if (w_level) begin
                    if (w_done) begin
                        w_state_next = WAIT_PRESS;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_cnt_next = '0;
                end
            end
            default: begin
                w_state_next = WAIT_PRESS;
                w_cnt_next   = '0;
            end
        endcase
    end

endmodule

module accumulating_adder #(
    parameter int WIDTH           = 8,
    parameter int ACC_WIDTH       = 12,
    parameter int DIGITS          = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SATURATE        = 0,
    parameter int ZERO_SUPPRESS   = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      SW,
    input  logic                  SUB,
    input  logic                  KEY_ADD,
    input  logic                  KEY_CLR,
    output logic [7*DIGITS-1:0]   HEX,
    output logic [WIDTH+1:0]      LEDR
);

    logic                   w_add_pulse;
    logic                   w_clr_pulse;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic                   r_ovf;
    logic [ACC_WIDTH-1:0]   w_sw_ext;
    logic [ACC_WIDTH:0]     w_sum;
    logic [ACC_WIDTH:0]     w_diff;
    logic [4*DIGITS-1:0]    w_acc_ext;
    logic [7*DIGITS-1:0]    w_hex;

    // Bit ACC_WIDTH of the result is the carry (add) or borrow (subtract).
    function automatic logic [ACC_WIDTH-1:0] f_resolve(input logic [ACC_WIDTH:0] result,
                                                       input logic is_sub);
        if ((SATURATE != 0) && result[ACC_WIDTH])
            return is_sub ? '0 : '1;
        else
            return result[ACC_WIDTH-1:0];
    endfunction

    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_add (
        .clk     (CLOCK_50),
        .reset   (reset),
        .i_key_n (KEY_ADD),
        .o_pulse (w_add_pulse)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clr (
        .clk     (CLOCK_50),
        .reset   (reset),
        .i_key_n (KEY_CLR),
        .o_pulse (w_clr_pulse)
    );

    always_comb begin
        w_sw_ext = '0;
        w_sw_ext[WIDTH-1:0] = SW;
    end

    assign w_sum  = {1'b0, r_acc} + {1'b0, w_sw_ext};
    assign w_diff = {1'b0, r_acc} - {1'b0, w_sw_ext};

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_clr_pulse) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_add_pulse) begin
            if (SUB) begin
                r_acc <= f_resolve(w_diff, 1'b1);
                r_ovf <= r_ovf | w_diff[ACC_WIDTH];
            end else begin
                r_acc <= f_resolve(w_sum, 1'b0);
                r_ovf <= r_ovf | w_sum[ACC_WIDTH];
            end
        end
    end

    always_comb begin
        w_acc_ext = '0;
        w_acc_ext[ACC_WIDTH-1:0] = r_acc;
    end

    // A higher digit is blanked only when it and every digit above it are zero.
    always_comb begin
        w_hex = '1;
        for (int i = 0; i < DIGITS; i++) begin
            w_hex[7*i +: 7] = f_glyph(w_acc_ext[4*i +: 4]);
            if ((ZERO_SUPPRESS != 0) && (i > 0) && ((w_acc_ext >> (4*i)) == '0))
                w_hex[7*i +: 7] = 7'h7F;
        end
    end

    assign HEX  = w_hex;
    assign LEDR = {SUB, r_ovf, SW};

endmodule

// File: tb/tb_accumulating_adder.sv
// Randomised self-checking bench for accumulating_adder: wrapping and saturating
// instances share stimulus and are compared against a press-level arithmetic model.

module tb_accumulating_adder;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [7:0]  SW;
    logic        SUB;
    logic        KEY_ADD;
    logic        KEY_CLR;
    logic [20:0] hex_w;
    logic [20:0] hex_s;
    logic [9:0]  ledr_w;
    logic [9:0]  ledr_s;

    int total = 0;
    int bad   = 0;
    int acc_m [2];
    bit ovf_m [2];

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    always #10 CLOCK_50 = ~CLOCK_50;

    accumulating_adder #(.DEBOUNCE_CYCLES(4), .SATURATE(0)) dut_wrap (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .SW       (SW),
        .SUB      (SUB),
        .KEY_ADD  (KEY_ADD),
        .KEY_CLR  (KEY_CLR),
        .HEX      (hex_w),
        .LEDR     (ledr_w)
    );

    accumulating_adder #(.DEBOUNCE_CYCLES(4), .SATURATE(1)) dut_sat (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .SW       (SW),
        .SUB      (SUB),
        .KEY_ADD  (KEY_ADD),
        .KEY_CLR  (KEY_CLR),
        .HEX      (hex_s),
        .LEDR     (ledr_s)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] exp_hex(input int a);
        logic [20:0] r;
        r = '0;
        for (int d = 0; d < 3; d++) begin
            if (d > 0 && (a >> (4*d)) == 0)
                r[7*d +: 7] = 7'h7F;
            else
                r[7*d +: 7] = GLYPH[(a >> (4*d)) & 15];
        end
        return r;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    // Model index 0 wraps modulo 4096, index 1 clamps.
    task automatic model_op(input bit is_clr, input int sw, input bit sub);
        for (int s = 0; s < 2; s++) begin
            if (is_clr) begin
                acc_m[s] = 0;
                ovf_m[s] = 1'b0;
            end else if (sub) begin
                if (sw > acc_m[s]) begin
                    ovf_m[s] = 1'b1;
                    acc_m[s] = (s == 1) ? 0 : acc_m[s] - sw + 4096;
                end else begin
                    acc_m[s] = acc_m[s] - sw;
                end
            end else begin
                acc_m[s] = acc_m[s] + sw;
                if (acc_m[s] > 4095) begin
                    ovf_m[s] = 1'b1;
                    acc_m[s] = (s == 1) ? 4095 : acc_m[s] - 4096;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        @(negedge CLOCK_50);
        check_eq({tag, "_hex_wrap"},  32'(hex_w),  32'(exp_hex(acc_m[0])));
        check_eq({tag, "_hex_sat"},   32'(hex_s),  32'(exp_hex(acc_m[1])));
        check_eq({tag, "_ledr_wrap"}, 32'(ledr_w), 32'({SUB, ovf_m[0], SW}));
        check_eq({tag, "_ledr_sat"},  32'(ledr_s), 32'({SUB, ovf_m[1], SW}));
        @(posedge CLOCK_50);
        #1;
    endtask

    // A key held low for at least 4 cycles is one accepted press.
    task automatic press(input logic [7:0] sw, input bit sub, input int hold,
                         input bit do_add, input bit do_clr);
        SW      = sw;
        SUB     = sub;
        KEY_ADD = do_add ? 1'b0 : 1'b1;
        KEY_CLR = do_clr ? 1'b0 : 1'b1;
        cycles(hold);
        KEY_ADD = 1'b1;
        KEY_CLR = 1'b1;
        cycles(10);
        if (hold >= 4) begin
            if (do_clr)
                model_op(1'b1, 0, 1'b0);
            else if (do_add)
                model_op(1'b0, int'(sw), sub);
        end
    endtask

    initial begin
        reset   = 1'b1;
        SW      = 8'h00;
        SUB     = 1'b0;
        KEY_ADD = 1'b1;
        KEY_CLR = 1'b1;
        acc_m   = '{0, 0};
        ovf_m   = '{1'b0, 1'b0};
        cycles(3);
        reset = 1'b0;
        cycles(2);
        check_eq("rst_dig0", 32'(hex_w[6:0]), 32'h40);
        check_eq("rst_dig21", 32'(hex_w[20:7]), 32'h3FFF);
        check_eq("rst_ovf", 32'(ledr_w[8]), 32'h0);
        check_all("rst");

        for (int k = 0; k < 3; k++) press(8'h2A, 1'b0, 20, 1'b1, 1'b0);
        check_eq("sum_7E", 32'(hex_w), 32'(exp_hex(12'h07E)));
        check_eq("sum_7E_dig2", 32'(hex_w[20:14]), 32'h7F);
        check_all("sum3");

        KEY_ADD = 1'b0; cycles(2);
        KEY_ADD = 1'b1; cycles(1);
        press(8'h2A, 1'b0, 20, 1'b1, 1'b0);
        check_eq("bounce_one", 32'(hex_w), 32'(exp_hex(12'h0A8)));
        check_all("bounce");
        press(8'h2A, 1'b0, 3, 1'b1, 1'b0);
        check_eq("short_none", 32'(hex_w), 32'(exp_hex(12'h0A8)));
        check_all("short");

        press(8'h00, 1'b0, 6, 1'b0, 1'b1);
        for (int k = 0; k < 16; k++) press(8'hFF, 1'b0, 6, 1'b1, 1'b0);
        check_all("ff0");
        press(8'h20, 1'b0, 6, 1'b1, 1'b0);
        check_eq("ovf_wrap_val", 32'(hex_w), 32'(exp_hex(12'h010)));
        check_eq("ovf_sat_val", 32'(hex_s), 32'(exp_hex(12'hFFF)));
        check_eq("ovf_sticky", 32'({ledr_w[8], ledr_s[8]}), 32'h3);
        check_all("ovf_add");

        press(8'h00, 1'b0, 6, 1'b0, 1'b1);
        press(8'h05, 1'b0, 6, 1'b1, 1'b0);
        press(8'h09, 1'b1, 6, 1'b1, 1'b0);
        check_eq("borrow_wrap", 32'(hex_w), 32'(exp_hex(12'hFFC)));
        check_eq("borrow_sat", 32'(hex_s), 32'(exp_hex(12'h000)));
        check_all("borrow");
        press(8'h09, 1'b1, 6, 1'b0, 1'b1);
        check_eq("clr_ovf", 32'(ledr_w[8]), 32'h0);
        check_all("clr");

        press(8'h80, 1'b0, 8, 1'b1, 1'b0);
        press(8'h80, 1'b0, 8, 1'b1, 1'b0);
        check_eq("acc_100", 32'(hex_w), 32'(exp_hex(12'h100)));
        press(8'h80, 1'b0, 20, 1'b1, 1'b1);
        check_eq("clr_wins", 32'(hex_w), 32'(exp_hex(12'h000)));
        check_all("both");

        press(8'h33, 1'b0, 6, 1'b1, 1'b0);
        KEY_ADD = 1'b0; cycles(2);
        reset = 1'b1; cycles(1);
        reset = 1'b0; KEY_ADD = 1'b1; cycles(10);
        model_op(1'b1, 0, 1'b0);
        check_eq("rst_mid_deb", 32'(hex_w), 32'(exp_hex(12'h000)));
        check_all("rst_mid");

        SW = 8'h11; SUB = 1'b0;
        KEY_ADD = 1'b0; cycles(3);
        reset = 1'b1; cycles(1);
        reset = 1'b0; cycles(20);
        KEY_ADD = 1'b1; cycles(10);
        model_op(1'b0, 32'h11, 1'b0);
        check_eq("held_thru_rst", 32'(hex_w), 32'(exp_hex(12'h011)));
        check_all("held");

        for (int k = 0; k < 40; k++) begin
            logic [7:0] sw_r;
            bit         sub_r;
            int         hold_r;
            bit         clr_r;
            sw_r   = 8'($urandom_range(0, 255));
            sub_r  = 1'($urandom_range(0, 1));
            hold_r = $urandom_range(1, 12);
            clr_r  = ($urandom_range(0, 9) == 0);
            press(sw_r, sub_r, hold_r, !clr_r, clr_r);
            check_all("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/accumulating_adder.md
Name: accumulating_adder

Overview:
- Sequential, parametrised next generation of the board adding machine.
- Adds or subtracts a switch operand into a registered accumulator, once per debounced pushbutton press.
- Drives a DIGITS-wide active-low hex 7-segment display and status LEDs.
- Top-level board block: SW/KEY in, HEX/LEDR out.

Parameters:
- WIDTH, 8, operand width in bits (SW[WIDTH-1:0]).
- ACC_WIDTH, 12, accumulator width; must be >= WIDTH.
- DIGITS, 3, hex digits displayed; must satisfy 4*DIGITS >= ACC_WIDTH.
- DEBOUNCE_CYCLES, 500000, cycles a key level must be stable before acceptance; 0 bypasses the debounce wait.
- SATURATE, 0, overflow mode: 0 = wrap modulo 2^ACC_WIDTH, 1 = clamp to all-ones/zero.
- ZERO_SUPPRESS, 1, 1 = blank leading zero digits; digit 0 is always lit.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- SW  in  WIDTH  operand value, unsigned.
- SUB  in  1  0 = add, 1 = subtract; sampled on the accepted press.
- KEY_ADD  in  1  active-low pushbutton; each press = one operation.
- KEY_CLR  in  1  active-low pushbutton; press clears the accumulator.
- HEX  out  7*DIGITS  active-low segments. Digit i occupies [7i+6:7i]; bit 0 = segment a … bit 6 = segment g.
- LEDR  out  WIDTH+2  [WIDTH-1:0] = SW echo; [WIDTH] = sticky overflow; [WIDTH+1] = SUB echo.

Behaviour:
- Clock/reset: one clock, CLOCK_50. Reset is synchronous and active-high, named reset; reset inside an always block on posedge CLOCK_50.
- Reset values:
  - acc = 0, ovf = 0.
  - Key FSMs in WAIT_PRESS with debounce counters at 0.
  - Synchronisers = 2'b11 (released).
  - HEX shows "0" on digit 0; other digits blank when ZERO_SUPPRESS=1, else "0".
- Input path: KEY_ADD and KEY_CLR each pass a 2-flop synchroniser, then an independent key FSM.
- Key FSM states:
  - WAIT_PRESS: counter counts while synced level = 0, resets to 0 on any 1. When count reaches DEBOUNCE_CYCLES, go to FIRE.
  - FIRE: exactly one-cycle pulse, then go to WAIT_RELEASE.
  - WAIT_RELEASE: counter counts while level = 1, resets on 0. When count reaches DEBOUNCE_CYCLES, go to WAIT_PRESS.
  - DEBOUNCE_CYCLES = 0: transition on the first cycle the synced level qualifies.
  - A held key produces exactly one pulse; bounce shorter than DEBOUNCE_CYCLES produces none.
- Accumulator update on the clock edge where the pulse is high:
  - add_pulse, SUB=0: acc <= acc + zero-extended SW.
  - add_pulse, SUB=1: acc <= acc - zero-extended SW.
  - clr_pulse: acc <= 0, ovf <= 0.
  - clr_pulse and add_pulse in the same cycle: clear wins; the add is dropped.
- Overflow:
  - Add overflow = carry out of bit ACC_WIDTH-1. Subtract overflow = borrow (SW > acc).
  - Either event sets ovf sticky until clr_pulse or reset.
  - SATURATE=0: result wraps.
  - SATURATE=1: add clamps to 2^ACC_WIDTH-1; subtract clamps to 0.
- Latency with DEBOUNCE_CYCLES=0: KEY_ADD low sampled at edge n → sync at n+2 → FIRE at n+3 → acc updated at edge n+4.
- Display:
  - Combinational decode of registered acc, so it changes in the same cycle as acc.
  - Glyphs 0-9, A, b, C, d, E, F.
  - Digit i shows acc nibble [4i+3:4i]; bits above ACC_WIDTH read as 0.
  - Blank = 7'h7F.
  - With ZERO_SUPPRESS=1, digit i>0 is blank iff all nibbles ≥ i are zero.
- Reset asserted mid-debounce or mid-press: FSM returns to WAIT_PRESS. A key still held after reset must first be seen pressed for DEBOUNCE_CYCLES, so it fires once.
- LEDR is a combinational echo of SW and SUB, plus registered ovf.

Test Plan (DEBOUNCE_CYCLES=4 unless noted; defaults otherwise):
- Reset then idle → HEX digit0 = 7'b1000000 ("0"), digits 1-2 = 7'h7F, LEDR[8] = 0.
- SW=8'h2A, press KEY_ADD 20 cycles ×3 → acc = 12'h07E; HEX shows "7E" with digit2 blank; exactly 3 updates.
- KEY_ADD bounce (low 2 cycles, high 1, low 20) → exactly one add. Low for only 3 cycles → no add.
- acc=12'hFF0, SW=8'h20, add → SATURATE=0: acc = 12'h010, ovf=1. SATURATE=1: acc = 12'hFFF, ovf=1.
- acc=12'h005, SUB=1, SW=8'h09 → wrap: acc = 12'hFFC, ovf=1. Then KEY_CLR → acc=0, ovf=0.
- KEY_ADD and KEY_CLR pressed in the same cycle with acc=12'h100 → acc=0 (clear wins). reset asserted mid-debounce → no pulse; acc=0.
